// File: rtl/key_debouncer.sv
// Multi-key push-button debouncer: 2-flop sync, stable-count filter, press/release pulses.
// Define KEY_DEBOUNCER_AUTOREPEAT_EN to build the per-key auto-repeat pulse generator.
module key_debouncer_lane #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic state,
  output logic press,
  output logic rel,
  output logic rpt
);
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST     = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic          IDLE_RAW = (ACTIVE_LOW != 0);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level, mismatch, toggle;

  assign level    = sync[1] ^ IDLE_RAW;
  assign mismatch = level != state;
  // The counter never passes LAST: the accepting cycle clears it together with the toggle.
  assign toggle   = mismatch && (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync  <= {2{IDLE_RAW}};
      state <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= toggle & ~state;
      rel   <= toggle & state;
      if (!mismatch || toggle) cnt <= '0;
      else                     cnt <= cnt + 1'b1;
      if (toggle) state <= ~state;
    end
  end

`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
  localparam int            RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int            RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] R_DLY = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] R_PER = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rcnt;

  // Down-counter reloaded at the press; each expiry emits a pulse and reloads with the period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rcnt <= '0;
      rpt  <= 1'b0;
    end else if (toggle && !state) begin
      rcnt <= R_DLY;
      rpt  <= 1'b0;
    end else if (!state || toggle) begin
      rcnt <= '0;
      rpt  <= 1'b0;
    end else if (rcnt == '0) begin
      rcnt <= R_PER;
      rpt  <= 1'b1;
    end else begin
      rcnt <= rcnt - 1'b1;
      rpt  <= 1'b0;
    end
  end
`else
  assign rpt = 1'b0;
`endif
endmodule

module key_debouncer #(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] repeat_pulse
);
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_lane
    key_debouncer_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (key_raw[g]),
      .state  (key_state[g]),
      .press  (press_pulse[g]),
      .rel    (release_pulse[g]),
      .rpt    (repeat_pulse[g])
    );
  end
endmodule

// File: tb/tb_key_debouncer.sv
// Scoreboarded random/directed bench for key_debouncer against a sliding-window reference model.
module tb_key_debouncer;
  localparam int NK = 3, DC = 4, AL = 1, HL = DC + 2;
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
  localparam int RD = 10, RP = 5;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NK-1:0] key_raw, key_state, press_pulse, release_pulse, repeat_pulse;

  typedef struct packed {
    logic [NK-1:0] st, pr, rl, rp;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0, miscompares = 0;

  // Model state: last HL pressed-samples per key (index 0 newest), accepted level, cycles held.
  bit hist[NK][HL];
  bit m_state[NK];
  int age[NK];

  always #5 clk = ~clk;

  key_debouncer #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DC), .ACTIVE_LOW(AL),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
  ) dut (
    .clk(clk), .reset_n(reset_n), .key_raw(key_raw), .key_state(key_state),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .repeat_pulse(repeat_pulse)
  );

  function automatic obs_t dut_obs();
    return obs_t'({key_state, press_pulse, release_pulse, repeat_pulse});
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s t=%0t: got st=%b pr=%b rl=%b rp=%b, want st=%b pr=%b rl=%b rp=%b",
               name, $time, got.st, got.pr, got.rl, got.rp, want.st, want.pr, want.rl, want.rp);
    end
  endtask

  // A key's level is accepted once the last DC synchronized samples (2 edges of sync latency)
  // all disagree with the currently accepted level.
  task automatic model(input logic [NK-1:0] raw, input bit rst_lvl);
    obs_t e;
    bit   all_diff;
    e = '0;
    for (int k = 0; k < NK; k++) begin
      if (!rst_lvl) begin
        for (int j = 0; j < HL; j++) hist[k][j] = 1'b0;
        m_state[k] = 1'b0;
        age[k]     = 0;
      end else begin
        for (int j = HL - 1; j > 0; j--) hist[k][j] = hist[k][j-1];
        hist[k][0] = (AL != 0) ? ~raw[k] : raw[k];
        all_diff = 1'b1;
        for (int j = 2; j < HL; j++) if (hist[k][j] == m_state[k]) all_diff = 1'b0;
        if (all_diff) begin
          if (m_state[k]) e.rl[k] = 1'b1;
          else            e.pr[k] = 1'b1;
          m_state[k] = !m_state[k];
          age[k]     = 0;
        end else if (m_state[k]) begin
          age[k]++;
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
          if (age[k] >= RD && (age[k] - RD) % RP == 0) e.rp[k] = 1'b1;
`endif
        end
        e.st[k] = m_state[k];
      end
    end
    exp_q.push_back(e);
  endtask

  // One clock of stimulus: inputs change at the falling edge, reset asserts 2 ns after it.
  task automatic cyc(input logic [NK-1:0] raw, input bit rst_lvl);
    @(negedge clk);
    key_raw = raw;
    if (rst_lvl) reset_n = 1'b1;
    else if (reset_n) begin
      #2 reset_n = 1'b0;
      #1 check("async_reset", dut_obs(), '0);
    end
    model(raw, rst_lvl);
  endtask

  task automatic hold(input logic [NK-1:0] raw, input int n);
    for (int i = 0; i < n; i++) cyc(raw, 1'b1);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) check("outputs", dut_obs(), exp_q.pop_front());
    end
  end

  initial begin : stimulus
    logic [NK-1:0] r;
    bit            rst;
    key_raw = '1;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1 check("async_reset_init", dut_obs(), '0);
    model(key_raw, 1'b0);
    cyc(3'b111, 1'b0);
    hold(3'b111, 4);
    hold(3'b110, 36);                 // key 0 press and long hold
    hold(3'b111, 10);
    hold(3'b101, 3);                  // glitch on key 1 shorter than the filter
    hold(3'b111, 10);
    hold(3'b010, 10);                 // keys 0 and 2 together
    hold(3'b111, 10);
    hold(3'b110, 4);                  // press key 0, reset at count 2
    cyc(3'b110, 1'b0);
    hold(3'b110, 12);
    hold(3'b111, 10);
    r = '1;
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < NK; k++) if ($urandom_range(0, 4) == 0) r[k] = ~r[k];
      rst = ($urandom_range(0, 199) != 0);
      cyc(r, rst);
    end
    hold(3'b111, 12);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #3;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
